// File: rtl/pconv_mux.sv
// pconv_mux: time-multiplexed 1x1 convolution; PE MAC lanes sweep OUTPUT_CHANNEL/PE passes per pixel.
// Define PCONV_MUX_RELU_EN to compile in the run-time ReLU stage (relu_en); otherwise relu_en is ignored.

module pconv_lane #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                clr,
  input  logic                mac,
  input  logic signed [N-1:0] x,
  input  logic signed [N-1:0] w,
  input  logic signed [31:0]  bias,
  input  logic        [4:0]   shift,
  output logic signed [N-1:0] y
);
  localparam int MAXV = (1 <<< (N-1)) - 1;
  localparam int MINV = -(1 <<< (N-1));

  logic signed [31:0]    acc;
  logic signed [2*N-1:0] prod;
  logic signed [31:0]    sum;
  logic signed [31:0]    shr;

  assign prod = x * w;

  always_ff @(posedge clk) begin
    if (rst)       acc <= '0;
    else if (ce) begin
      if (clr)      acc <= '0;
      else if (mac) acc <= acc + 32'(prod);
    end
  end

  // requantise: bias add and shift wrap at 32 bits, then saturate to N bits
  always_comb begin
    sum = acc + bias;
    shr = sum >>> shift;
    if (shr > MAXV)      y = MAXV[N-1:0];
    else if (shr < MINV) y = MINV[N-1:0];
    else                 y = shr[N-1:0];
  end
endmodule

module pconv_mux #(
  parameter int N              = 16,
  parameter int INPUT_CHANNEL  = 8,
  parameter int OUTPUT_CHANNEL = 16,
  parameter int PE             = 4,
  parameter int INPUT_SIZE     = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ce,
  input  logic                                  input_vld,
  output logic                                  input_rdy,
  input  logic [INPUT_CHANNEL*N-1:0]            input_din,
  input  logic [INPUT_CHANNEL*OUTPUT_CHANNEL*N-1:0] weight_din,
  input  logic [OUTPUT_CHANNEL*32-1:0]          bias_din,
  input  logic [OUTPUT_CHANNEL*5-1:0]           shift_din,
  input  logic                                  relu_en,
  output logic [OUTPUT_CHANNEL*N-1:0]           conv_dout,
  output logic                                  conv_dout_vld,
  input  logic                                  conv_dout_rdy,
  output logic                                  conv_dout_end
);
  localparam int PASSES = OUTPUT_CHANNEL / PE;
  localparam int NPIX   = INPUT_SIZE * INPUT_SIZE;
  localparam int IW     = (INPUT_CHANNEL > 1)  ? $clog2(INPUT_CHANNEL)  : 1;
  localparam int PW     = (PASSES > 1)         ? $clog2(PASSES)         : 1;
  localparam int OW     = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1;
  localparam int XW     = (NPIX > 1)           ? $clog2(NPIX)           : 1;

  typedef enum logic [1:0] {IDLE, MAC, REQ, OUT} state_t;
  state_t state, nxt;

  logic [INPUT_CHANNEL-1:0][N-1:0]                      din, pixel;
  logic [OUTPUT_CHANNEL-1:0][INPUT_CHANNEL-1:0][N-1:0]  wt;
  logic [OUTPUT_CHANNEL-1:0][31:0]                      bias;
  logic [OUTPUT_CHANNEL-1:0][4:0]                       shift;
  logic [OUTPUT_CHANNEL-1:0][N-1:0]                     dout;
  logic [PE-1:0][N-1:0]                                 y_lane, y_out;
  logic [PE-1:0][OW-1:0]                                oc_idx;

  logic [IW-1:0] ic_cnt;
  logic [PW-1:0] pass_cnt;
  logic [XW-1:0] pix_cnt;
  logic          vld, frame_end;
  logic          accept, acc_clr, acc_mac;
  logic          ic_last, pass_last, pix_last;

  assign din   = input_din;
  assign wt    = weight_din;
  assign bias  = bias_din;
  assign shift = shift_din;

  assign conv_dout     = dout;
  assign conv_dout_vld = vld;
  assign conv_dout_end = frame_end;

  assign input_rdy = ce && (state == IDLE) && !rst;
  assign accept    = input_vld && input_rdy;
  assign ic_last   = (ic_cnt == IW'(INPUT_CHANNEL - 1));
  assign pass_last = (pass_cnt == PW'(PASSES - 1));
  assign pix_last  = (pix_cnt == XW'(NPIX - 1));

  for (genvar p = 0; p < PE; p++) begin : g_lane
    assign oc_idx[p] = OW'(int'(pass_cnt) * PE + p);
    pconv_lane #(.N(N)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .clr   (acc_clr),
      .mac   (acc_mac),
      .x     (pixel[ic_cnt]),
      .w     (wt[oc_idx[p]][ic_cnt]),
      .bias  (bias[oc_idx[p]]),
      .shift (shift[oc_idx[p]]),
      .y     (y_lane[p])
    );
  end

`ifdef PCONV_MUX_RELU_EN
  always_comb begin
    y_out = y_lane;
    for (int p = 0; p < PE; p++)
      if (relu_en && y_lane[p][N-1]) y_out[p] = '0;
  end
`else
  logic relu_unused;
  assign relu_unused = relu_en;
  assign y_out       = y_lane;
`endif

  always_ff @(posedge clk) begin
    if (rst)     state <= IDLE;
    else if (ce) state <= nxt;
  end

  always_comb begin
    nxt     = state;
    acc_clr = 1'b0;
    acc_mac = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        nxt     = MAC;
        acc_clr = 1'b1;
      end
      MAC: begin
        acc_mac = 1'b1;
        if (ic_last) nxt = REQ;
      end
      REQ: if (!pass_last) begin
        nxt     = MAC;
        acc_clr = 1'b1;
      end else begin
        nxt = OUT;
      end
      OUT: if (conv_dout_rdy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // only the PE slots of the current pass are written; the rest hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel     <= '0;
      ic_cnt    <= '0;
      pass_cnt  <= '0;
      pix_cnt   <= '0;
      dout      <= '0;
      vld       <= 1'b0;
      frame_end <= 1'b0;
    end else if (ce) begin
      unique case (state)
        IDLE: if (accept) begin
          pixel    <= din;
          ic_cnt   <= '0;
          pass_cnt <= '0;
        end
        MAC: ic_cnt <= ic_last ? '0 : ic_cnt + 1'b1;
        REQ: begin
          for (int p = 0; p < PE; p++) dout[oc_idx[p]] <= y_out[p];
          if (!pass_last) pass_cnt <= pass_cnt + 1'b1;
          else begin
            vld       <= 1'b1;
            frame_end <= pix_last;
          end
        end
        OUT: if (conv_dout_rdy) begin
          vld       <= 1'b0;
          frame_end <= 1'b0;
          pix_cnt   <= pix_last ? '0 : pix_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
